regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//  Integer register file: the consuming end of the writeback path. Accepts the selected
//  writeback value (valW) and its destination, and serves decode with two operand reads.
//  A per-register busy scoreboard tracks in-flight producers, so decode stalls on RAW/WAW
//  hazards. Sits between IDU (read/issue side) and WBU (write side) in the pipelined core.
// PARAMETERS
//  WIDTH   32  data width of each register and of valW/valA/valB
//  NREG    32  number of architectural registers (x0..x(NREG-1)); must be a power of 2
//  AW      5   register index width, = log2(NREG)
// PORTS
//  clk           in   1      core clock, all state updates on rising edge
//  rst_n         in   1      asynchronous active-low reset
//  IDU_i_rs1     in   AW     source register 1 index
//  IDU_i_rs2     in   AW     source register 2 index
//  IDU_i_rd      in   AW     destination of the instruction being issued
//  IDU_i_issue   in   1      decode requests issue of an instruction that writes IDU_i_rd
//  REG_o_valA    out  WIDTH  operand A = x[rs1], bypassed
//  REG_o_valB    out  WIDTH  operand B = x[rs2], bypassed
//  REG_o_stall   out  1      issue blocked this cycle (hazard); combinational
//  WBU_i_wen     in   1      writeback valid
//  WBU_i_rd      in   AW     writeback destination
//  WBU_i_valW    in   WIDTH  writeback data
// BEHAVIOUR
//  Reset (async, rst_n=0): all registers <= 0, all busy bits <= 0. With no writeback active,
//   valA=valB=0 and stall=0 immediately; reset mid-operation discards all pending busy state.
//  Reads: combinational, zero latency. x0 always reads 0. If WBU_i_wen && WBU_i_rd==rsN && rsN!=0,
//   valN = WBU_i_valW (same-cycle write-through bypass); else stored value.
//  Write: at posedge, if WBU_i_wen && WBU_i_rd!=0, x[WBU_i_rd] <= WBU_i_valW. Writes to x0 dropped.
//  Effective busy for hazard check: ebusy[r] = busy[r] && !(WBU_i_wen && WBU_i_rd==r). busy[0]==0 always.
//  Stall: REG_o_stall = IDU_i_issue && (ebusy[rs1] || ebusy[rs2] || ebusy[rd]). Zero when issue=0.
//   rs1/rs2 checked unconditionally (decode passes 0 for unused sources).
//  Scoreboard update at posedge, per register r!=0:
//   set   = IDU_i_issue && !REG_o_stall && IDU_i_rd==r
//   clear = WBU_i_wen && WBU_i_rd==r
//   set wins over clear (new producer issued same cycle the old one retires) -> busy stays 1.
//   clear of a non-busy register is legal, no effect on busy (value still written).
//  At most one outstanding producer per register (WAW stalls guarantee this).
//  No X propagation: out-of-range indices impossible (AW exact); unused issue with X rd ignored.
// STRUCTURE
//  Shared package/defines: WIDTH/NREG/AW constants, REG_ZERO index (0).
//  One natural sub-module: regfile_scoreboard_bits (NREG busy flops, set/clear priority,
//   ebusy vector out); storage array and bypass muxes stay in the top.
// TESTING
//  1 reset then read rs1=3,rs2=0 -> valA=0,valB=0,stall=0; all busy=0.
//  2 wen=1,rd=5,valW=0xDEADBEEF with rs1=5 same cycle -> valA=0xDEADBEEF (bypass); next cycle
//    without wen -> valA=0xDEADBEEF from storage.
//  3 wen=1,rd=0,valW=0x1234 -> x0 still reads 0; issue rd=0 never sets busy nor stalls.
//  4 issue rd=7 (accepted); next cycle issue rs1=7 -> stall=1; later wen rd=7 valW=0x55 with
//    same issue pending -> stall=0, valA=0x55, busy[7] cleared after edge.
//  5 busy[9]=1; same cycle wen rd=9 and issue rd=9 -> no stall, busy[9]=1 after edge, x9=valW.
//  6 issue rd=4 accepted, assert rst_n=0 mid-cycle -> busy[4]=0, x4=0 immediately, stall=0.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// regfile_scoreboard_pkg: shared sizes and the hard-wired zero register index
package regfile_scoreboard_pkg;
  localparam int WIDTH = 32;
  localparam int NREG = 32;
  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/regfile_scoreboard_bits.sv
// regfile_scoreboard_bits: per-register busy flops with set-over-clear priority
// Ports: clk, rst_n (async active-low); set_i/set_rd_i mark a newly issued producer,
//  clr_i/clr_rd_i retire a producer at writeback; ebusy_o is busy with the same-cycle
//  retirement already discounted, used by the hazard check.
module regfile_scoreboard_bits
  import regfile_scoreboard_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_i,
  input  logic [AW-1:0]   set_rd_i,
  input  logic            clr_i,
  input  logic [AW-1:0]   clr_rd_i,
  output logic [NREG-1:0] ebusy_o
);
  logic [NREG-1:0] busy_q, busy_d, set_v, clr_v;
  always_comb begin
    set_v = set_i ? NREG'(1) << set_rd_i : '0;
    clr_v = clr_i ? NREG'(1) << clr_rd_i : '0;
    // set applied after clear so a producer issued as the old one retires keeps the bit;
    // bit 0 is forced low since x0 never has a producer
    busy_d = ((busy_q & ~clr_v) | set_v) & ~NREG'(1);
  end
  assign ebusy_o = busy_q & ~clr_v;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy_q <= '0;
    else busy_q <= busy_d;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with write-through bypass and busy scoreboard
// Ports: IDU_i_rs1/rs2 select operands REG_o_valA/valB (combinational, bypassed);
//  IDU_i_issue/IDU_i_rd request issue, REG_o_stall flags a RAW/WAW hazard;
//  WBU_i_wen/WBU_i_rd/WBU_i_valW write back and retire the producer.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    IDU_i_rs1,
  input  logic [AW-1:0]    IDU_i_rs2,
  input  logic [AW-1:0]    IDU_i_rd,
  input  logic             IDU_i_issue,
  output logic [WIDTH-1:0] REG_o_valA,
  output logic [WIDTH-1:0] REG_o_valB,
  output logic             REG_o_stall,
  input  logic             WBU_i_wen,
  input  logic [AW-1:0]    WBU_i_rd,
  input  logic [WIDTH-1:0] WBU_i_valW
);
  logic [WIDTH-1:0] regs_q [NREG];
  logic [NREG-1:0] ebusy;
  regfile_scoreboard_bits u_bits (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_i    (IDU_i_issue && !REG_o_stall),
    .set_rd_i (IDU_i_rd),
    .clr_i    (WBU_i_wen),
    .clr_rd_i (WBU_i_rd)
    ,.ebusy_o (ebusy)
  );
  always_comb begin
    REG_o_valA = IDU_i_rs1 == REG_ZERO ? '0 :
                 WBU_i_wen && WBU_i_rd == IDU_i_rs1 ? WBU_i_valW : regs_q[IDU_i_rs1];
    REG_o_valB = IDU_i_rs2 == REG_ZERO ? '0 :
                 WBU_i_wen && WBU_i_rd == IDU_i_rs2 ? WBU_i_valW : regs_q[IDU_i_rs2];
    // gating on issue first keeps an undriven rd from reaching the output
    REG_o_stall = IDU_i_issue && (ebusy[IDU_i_rs1] || ebusy[IDU_i_rs2] || ebusy[IDU_i_rd]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    else if (WBU_i_wen && WBU_i_rd != REG_ZERO) regs_q[WBU_i_rd] <= WBU_i_valW;
endmodule
